word_mismatch_monitor: RTL and testbench

WORD_MISMATCH_MONITOR -- requirements
Module: word_mismatch_monitor

---
 rtl/word_mismatch_monitor_if.sv | 24 ++
 rtl/word_mismatch_monitor.sv | 85 ++++++++
 tb/tb_word_mismatch_monitor.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/word_mismatch_monitor_if.sv
// Operand/result handshake bundle for word_mismatch_monitor.
//   in_valid  : a/b pair is valid this cycle         (master -> slave)
//   a, b      : 5-bit operand words                  (master -> slave)
//   in_ready  : slave accepts a pair this cycle      (slave -> master)
//   out_valid : one-cycle pulse, neq_q holds new result (slave -> master)
//   neq_q     : registered (a != b) of last accepted pair (slave -> master)
interface word_mismatch_monitor_if;
  logic       in_valid;
  logic [4:0] a;
  logic [4:0] b;
  logic       in_ready;
  logic       out_valid;
  logic       neq_q;

  modport master (
    output in_valid, a, b,
    input  in_ready, out_valid, neq_q
  );

  modport slave (
    input  in_valid, a, b,
    output in_ready, out_valid, neq_q
  );
endinterface

// File: rtl/word_mismatch_monitor.sv
// Compares accepted a/b word pairs, counts total and consecutive mismatches,
// and latches an alarm when the consecutive run reaches a live threshold.
//   clk            : rising-edge clock
//   reset          : synchronous active-high reset (priority over everything)
//   clear          : synchronous active-high clear of counters/state
//   bus            : operand/result handshake (slave side)
//   threshold      : consecutive-mismatch limit, 0 disables the alarm
//   mismatch_count : saturating total mismatch count
//   run_count      : saturating consecutive mismatch count
//   alarm          : high while in ALARM
//
// state   | meaning
// IDLE    | no pair accepted since reset/clear
// MONITOR | pairs being accepted and counted
// ALARM   | run reached threshold; input blocked, everything frozen
module word_mismatch_monitor (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  word_mismatch_monitor_if.slave        bus,
  input  logic [3:0]                    threshold,
  output logic [3:0]                    mismatch_count,
  output logic [3:0]                    run_count,
  output logic                          alarm
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    ALARM   = 2'd2
  } state_t;

  state_t     state_q;
  logic       res_q;
  logic       vld_q;
  logic [3:0] mis_q;
  logic [3:0] run_q;

  logic       accept;
  logic       neq;
  logic [3:0] mis_d;
  logic [3:0] run_d;
  logic       trip;

  assign bus.in_ready = (state_q != ALARM) && !clear;
  assign accept       = bus.in_valid && bus.in_ready;
  assign neq          = |(bus.a ^ bus.b);

  always_comb begin
    mis_d = mis_q;
    run_d = 4'd0;
    if (neq) begin
      mis_d = (mis_q == 4'hf) ? mis_q : mis_q + 4'd1;
      run_d = (run_q == 4'hf) ? run_q : run_q + 4'd1;
    end
    // Threshold is compared against the post-update run so the alarm
    // fires on the same edge that completes the run.
    trip = (threshold != 4'd0) && (run_d >= threshold);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= IDLE;
      res_q   <= 1'b0;
      vld_q   <= 1'b0;
      mis_q   <= 4'd0;
      run_q   <= 4'd0;
    end else begin
      vld_q <= accept;
      if (accept) begin
        res_q   <= neq;
        mis_q   <= mis_d;
        run_q   <= run_d;
        state_q <= trip ? ALARM : MONITOR;
      end
    end
  end

  assign bus.out_valid  = vld_q;
  assign bus.neq_q      = res_q;
  assign mismatch_count = mis_q;
  assign run_count      = run_q;
  assign alarm          = (state_q == ALARM);

endmodule

// File: tb/tb_word_mismatch_monitor.sv
module tb_word_mismatch_monitor;

  logic       clk;
  logic       reset;
  logic       clear;
  logic [3:0] threshold;
  logic [3:0] mismatch_count;
  logic [3:0] run_count;
  logic       alarm;

  int checks = 0;
  int errors = 0;

  word_mismatch_monitor_if bus_if ();

  word_mismatch_monitor dut (
    .clk            (clk),
    .reset          (reset),
    .clear          (clear),
    .bus            (bus_if.slave),
    .threshold      (threshold),
    .mismatch_count (mismatch_count),
    .run_count      (run_count),
    .alarm          (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       clr;
    logic       iv;
    logic [4:0] a;
    logic [4:0] b;
    logic [3:0] thr;
    logic       ov;
    logic       neq;
    logic [3:0] mc;
    logic [3:0] rc;
    logic       al;
    logic       rdy;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic rst, logic clr, logic iv, logic [4:0] a,
                              logic [4:0] b, logic [3:0] thr, logic ov,
                              logic neq, logic [3:0] mc, logic [3:0] rc,
                              logic al, logic rdy);
    vec_t t;
    t.rst = rst; t.clr = clr; t.iv = iv; t.a = a; t.b = b; t.thr = thr;
    t.ov = ov; t.neq = neq; t.mc = mc; t.rc = rc; t.al = al; t.rdy = rdy;
    return t;
  endfunction

  task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic drive(logic rst, logic clr, logic iv, logic [4:0] a,
                       logic [4:0] b, logic [3:0] thr);
    @(negedge clk);
    reset = rst; clear = clr; bus_if.in_valid = iv;
    bus_if.a = a; bus_if.b = b; threshold = thr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string nm, vec_t t);
    chk({nm, ".out_valid"}, {7'd0, bus_if.out_valid}, {7'd0, t.ov});
    chk({nm, ".neq_q"},     {7'd0, bus_if.neq_q},     {7'd0, t.neq});
    chk({nm, ".mis_cnt"},   {4'd0, mismatch_count},   {4'd0, t.mc});
    chk({nm, ".run_cnt"},   {4'd0, run_count},        {4'd0, t.rc});
    chk({nm, ".alarm"},     {7'd0, alarm},            {7'd0, t.al});
    chk({nm, ".in_ready"},  {7'd0, bus_if.in_ready},  {7'd0, t.rdy});
  endtask

  task automatic apply(string nm, vec_t t);
    drive(t.rst, t.clr, t.iv, t.a, t.b, t.thr);
    check_all(nm, t);
  endtask

  int pulses;

  initial begin
    reset = 1'b1; clear = 1'b0; threshold = 4'd0;
    bus_if.in_valid = 1'b0; bus_if.a = 5'd0; bus_if.b = 5'd0;

    //             rst clr iv  a      b      thr  ov neq mc  rc  al rdy
    // reset state
    tv.push_back(mk(1, 0, 0, 5'h00, 5'h00, 0,  0, 0, 0,  0,  0, 1));
    // equal pair then mismatch
    tv.push_back(mk(0, 0, 1, 5'h01, 5'h01, 0,  1, 0, 0,  0,  0, 1));
    tv.push_back(mk(0, 0, 1, 5'h05, 5'h03, 0,  1, 1, 1,  1,  0, 1));
    // idle cycle holds
    tv.push_back(mk(0, 0, 0, 5'h1f, 5'h00, 0,  0, 1, 1,  1,  0, 1));
    // clear drops the pair presented with it
    tv.push_back(mk(0, 1, 1, 5'h01, 5'h02, 0,  0, 0, 0,  0,  0, 0));
    // threshold 2: mismatch, equal, mismatch -> run 1,0,1
    tv.push_back(mk(0, 0, 1, 5'h00, 5'h01, 2,  1, 1, 1,  1,  0, 1));
    tv.push_back(mk(0, 0, 1, 5'h1f, 5'h1f, 2,  1, 0, 1,  0,  0, 1));
    tv.push_back(mk(0, 0, 1, 5'h03, 5'h02, 2,  1, 1, 2,  1,  0, 1));
    tv.push_back(mk(0, 1, 0, 5'h00, 5'h00, 2,  0, 0, 0,  0,  0, 0));
    // threshold 3: three mismatches -> alarm on the third edge
    tv.push_back(mk(0, 0, 1, 5'h15, 5'h0a, 3,  1, 1, 1,  1,  0, 1));
    tv.push_back(mk(0, 0, 1, 5'h1f, 5'h1e, 3,  1, 1, 2,  2,  0, 1));
    tv.push_back(mk(0, 0, 1, 5'h00, 5'h10, 3,  1, 1, 3,  3,  1, 0));
    // ALARM freezes: held pair and a threshold change do nothing
    tv.push_back(mk(0, 0, 1, 5'h07, 5'h00, 3,  0, 1, 3,  3,  1, 0));
    tv.push_back(mk(0, 0, 1, 5'h07, 5'h07, 1,  0, 1, 3,  3,  1, 0));
    // clear in ALARM with a mismatching pair -> IDLE, pair dropped
    tv.push_back(mk(0, 1, 1, 5'h01, 5'h00, 3,  0, 0, 0,  0,  0, 0));
    tv.push_back(mk(0, 0, 0, 5'h01, 5'h00, 3,  0, 0, 0,  0,  0, 1));
    // threshold 1: first mismatch alarms immediately from IDLE
    tv.push_back(mk(0, 0, 1, 5'h10, 5'h00, 1,  1, 1, 1,  1,  1, 0));
    // reset in ALARM with a pair presented -> reset values
    tv.push_back(mk(1, 0, 1, 5'h10, 5'h00, 1,  0, 0, 0,  0,  0, 1));
    // equal pair with threshold 1 does not alarm
    tv.push_back(mk(0, 0, 1, 5'h0c, 5'h0c, 1,  1, 0, 0,  0,  0, 1));
    tv.push_back(mk(0, 1, 0, 5'h00, 5'h00, 0,  0, 0, 0,  0,  0, 0));

    foreach (tv[i]) apply($sformatf("vec%0d", i), tv[i]);

    // 17 consecutive mismatches with the alarm disabled: both counters saturate
    pulses = 0;
    for (int i = 0; i < 17; i++) begin
      drive(0, 0, 1, 5'(i), 5'(i) ^ 5'h01, 0);
      if (bus_if.out_valid) pulses++;
    end
    chk("sat.pulses", pulses[7:0], 8'd17);
    check_all("sat", mk(0, 0, 0, 0, 0, 0, 1, 1, 15, 15, 0, 1));
    // one more idle then an equal pair: run clears, total stays saturated
    drive(0, 0, 0, 5'h00, 5'h00, 0);
    check_all("sat_idle", mk(0, 0, 0, 0, 0, 0, 0, 1, 15, 15, 0, 1));
    drive(0, 0, 1, 5'h09, 5'h09, 0);
    check_all("sat_eq", mk(0, 0, 0, 0, 0, 0, 1, 0, 15, 0, 0, 1));
    // rebuild a saturated run, then threshold 15 trips on the held-15 run
    for (int i = 0; i < 16; i++) drive(0, 0, 1, 5'h00, 5'h1f, 0);
    check_all("sat_run", mk(0, 0, 0, 0, 0, 0, 1, 1, 15, 15, 0, 1));
    drive(0, 0, 1, 5'h00, 5'h1f, 15);
    check_all("thr15", mk(0, 0, 0, 0, 0, 0, 1, 1, 15, 15, 1, 0));

    // MONITOR with five mismatches, then reset+clear+pair together
    drive(0, 1, 0, 5'h00, 5'h00, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 5'h02, 5'h04, 0);
    check_all("five", mk(0, 0, 0, 0, 0, 0, 1, 1, 5, 5, 0, 1));
    drive(1, 1, 1, 5'h02, 5'h04, 0);
    check_all("rst_clr", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(0, 0, 0, 5'h00, 5'h00, 0);
    check_all("post_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
